// File: rtl/signed_divider.sv
// signed_divider: sequential signed restoring divider.
// Each operation takes the operand magnitudes through N subtract-and-shift
// steps, then applies the quotient and remainder signs in a final FIX cycle.
// The quotient is truncated toward zero and the remainder takes the
// dividend's sign. Divide-by-zero skips the iterations entirely.
module signed_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] count_reg, count_next;
    // The partial remainder is one bit wider than the operands so that a
    // trial subtraction can go negative without losing information.
    logic [N:0]    part_reg, part_next;
    // Holds |dividend| at start; dividend bits shift out of the top while
    // quotient bits shift in at the bottom.
    logic [N-1:0]  qmag_reg, qmag_next;
    logic [N-1:0]  dsr_reg, dsr_next;
    logic          sign_q_reg, sign_q_next;
    logic          sign_r_reg, sign_r_next;
    logic          zero_reg, zero_next;
    logic          ovf_reg, ovf_next;

    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [N-1:0]  quotient_reg, quotient_next;
    logic [N-1:0]  remainder_reg, remainder_next;
    logic          dbz_out_reg, dbz_out_next;
    logic          ovf_out_reg, ovf_out_next;

    // Operand magnitudes. Negating the most negative value wraps back to
    // 2^(N-1), which is exactly the magnitude when read as unsigned.
    logic [N-1:0]  dividend_mag;
    logic [N-1:0]  divisor_mag;
    logic          dividend_is_min;
    logic          divisor_is_neg_one;

    // Single restoring step: shift in the next dividend MSB and try to
    // subtract the divisor magnitude.
    logic [N:0]    shifted;
    logic [N:0]    trial;

    // Signed results as they would be produced from the current magnitudes.
    logic [N-1:0]  q_signed;
    logic [N-1:0]  r_signed;
    logic [N-1:0]  dvd_restored;

    // Operand preprocessing: magnitudes and special-case detection.
    always_comb begin
        dividend_mag       = dividend[N-1] ? -dividend : dividend;
        divisor_mag        = divisor[N-1]  ? -divisor  : divisor;
        dividend_is_min    = (dividend == {1'b1, {(N-1){1'b0}}});
        divisor_is_neg_one = (divisor == {N{1'b1}});
    end

    // Datapath for one iteration and for the final sign correction.
    always_comb begin
        shifted      = {part_reg[N-1:0], qmag_reg[N-1]};
        trial        = shifted - {1'b0, dsr_reg};
        q_signed     = sign_q_reg ? -qmag_reg : qmag_reg;
        r_signed     = sign_r_reg ? -part_reg[N-1:0] : part_reg[N-1:0];
        // On divide-by-zero the dividend magnitude is still untouched in qmag.
        dvd_restored = sign_r_reg ? -qmag_reg : qmag_reg;
    end

    // Next-state and next-register logic for the IDLE/DIV/FIX sequence.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        part_next      = part_reg;
        qmag_next      = qmag_reg;
        dsr_next       = dsr_reg;
        sign_q_next    = sign_q_reg;
        sign_r_next    = sign_r_reg;
        zero_next      = zero_reg;
        ovf_next       = ovf_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_out_next   = dbz_out_reg;
        ovf_out_next   = ovf_out_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_q_next = dividend[N-1] ^ divisor[N-1];
                    sign_r_next = dividend[N-1];
                    qmag_next   = dividend_mag;
                    dsr_next    = divisor_mag;
                    part_next   = '0;
                    count_next  = '0;
                    busy_next   = 1'b1;
                    zero_next   = (divisor == '0);
                    ovf_next    = dividend_is_min && divisor_is_neg_one;
                    state_next  = (divisor == '0) ? FIX : DIV;
                end
            end

            DIV: begin
                if (!trial[N]) begin
                    part_next = trial;
                    qmag_next = {qmag_reg[N-2:0], 1'b1};
                end else begin
                    part_next = shifted;
                    qmag_next = {qmag_reg[N-2:0], 1'b0};
                end
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_ITER) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
                if (zero_reg) begin
                    quotient_next  = {N{1'b1}};
                    remainder_next = dvd_restored;
                    dbz_out_next   = 1'b1;
                    ovf_out_next   = 1'b0;
                end else begin
                    // The -2^(N-1)/-1 case wraps naturally to -2^(N-1).
                    quotient_next  = q_signed;
                    remainder_next = r_signed;
                    dbz_out_next   = 1'b0;
                    ovf_out_next   = ovf_reg;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            part_reg      <= '0;
            qmag_reg      <= '0;
            dsr_reg       <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_out_reg   <= 1'b0;
            ovf_out_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            part_reg      <= part_next;
            qmag_reg      <= qmag_next;
            dsr_reg       <= dsr_next;
            sign_q_reg    <= sign_q_next;
            sign_r_reg    <= sign_r_next;
            zero_reg      <= zero_next;
            ovf_reg       <= ovf_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_out_reg   <= dbz_out_next;
            ovf_out_reg   <= ovf_out_next;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        busy        = busy_reg;
        done        = done_reg;
        quotient    = quotient_reg;
        remainder   = remainder_reg;
        div_by_zero = dbz_out_reg;
        overflow    = ovf_out_reg;
    end

endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed vectors with a scoreboard queue; the monitor
// compares every done pulse against the oldest expected result.
module tb_signed_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    signed_divider #(.N(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) begin
                checks++;
                failures++;
                $display("FAIL busy_and_done actual=1 required=0");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done required=no_done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", {15'd0, div_by_zero}, {15'd0, e.dbz});
                    chk("overflow", {15'd0, overflow}, {15'd0, e.ovf});
                    $display("result q=0x%04h r=0x%04h dbz=%0b ovf=%0b", quotient, remainder, div_by_zero, overflow);
                end
            end
        end
    end

    // Waits (bounded) for done; optionally pokes start during busy and
    // confirms the previous result is still held at those points.
    task automatic wait_done(input int exp_lat, input bit poke, input logic [15:0] held_q);
        int lat;
        lat = 0;
        while (!done && lat < 40) begin
            if (poke && (lat == 3 || lat == 10)) begin
                chk("held_quotient", quotient, held_q);
                dividend = 16'd1;
                divisor  = 16'd1;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        chk("latency", 16'(lat), 16'(exp_lat));
    endtask

    // Drives one operation starting now (caller is just after a rising edge
    // or at a falling edge), pushes the expectation and waits for done.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input logic eovf,
                         input int exp_lat, input bit poke, input logic [15:0] held_q);
        exp_t e;
        e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {15'd0, busy}, 16'd1);
        wait_done(exp_lat, poke, held_q);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient", quotient, 16'd0);
        chk("reset_remainder", remainder, 16'd0);
        chk("reset_flags", {12'd0, busy, done, div_by_zero, overflow}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and sign matrix.
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(-16'd100, 16'd7, -16'd14, -16'd2, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(16'd100, -16'd7, -16'd14, 16'd2, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(-16'd100, -16'd7, 16'd14, -16'd2, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(-16'd7, 16'd2, -16'd3, -16'd1, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);

        // Boundaries.
        issue(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);
        issue(16'h7FFF, 16'h8000, 16'd0, 16'h7FFF, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);

        // Divide by zero: one-cycle latency.
        issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b0, 1, 1'b0, 16'd0);
        @(negedge clk);
        issue(-16'd5, 16'd0, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0, 1, 1'b0, 16'd0);
        @(negedge clk);

        // Start pulses during busy are ignored; previous quotient is held.
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 1'b1, 16'hFFFF);
        // Back-to-back: start raised in the done cycle.
        issue(16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 1'b0, 17, 1'b0, 16'd0);
        @(negedge clk);

        // Reset during iteration 8 aborts with no done pulse.
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_quotient", quotient, 16'd0);
        chk("abort_remainder", remainder, 16'd0);
        chk("abort_flags", {12'd0, busy, done, div_by_zero, overflow}, 16'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        issue(16'd1000, -16'd33, -16'd30, 16'd10, 1'b0, 1'b0, 17, 1'b0, 16'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed restoring divider for the signed-multiplier single-purpose processor datapath. It takes two's-complement dividend and divisor operands and produces a quotient truncated toward zero and a remainder carrying the dividend's sign. It performs one magnitude subtract-and-shift per clock and sits beside the multiplier as the inverse arithmetic unit. A start/done handshake is shared with the controller.

## Interface
- N, 16, operand/result width in bits (N ≥ 4)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  N  signed dividend; sampled on the accepting edge
- divisor  input  N  signed divisor; sampled on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid
- quotient  output  N  signed quotient
- remainder  output  N  signed remainder
- div_by_zero  output  1  divisor was 0 (valid with done, held)
- overflow  output  1  −2^(N−1) / −1 case (valid with done, held)

## Operation
- States: IDLE, DIV, FIX.
- **IDLE:** on start=1, register sign_q = dividend[N−1]^divisor[N−1] and sign_r = dividend[N−1]. Register the unsigned N-bit magnitudes |dividend| and |divisor|; |−2^(N−1)| = 2^(N−1) is exact as unsigned. Clear the (N+1)-bit partial remainder, load the count with 0, and assert busy.
  - If divisor == 0, go to FIX with the zero flag set and skip DIV.
  - Otherwise go to DIV.
- **DIV (N iterations):**
  - Shift the {partial remainder, quotient magnitude} pair left by one, bringing in the next dividend MSB.
  - Compute trial = partial − |divisor| in N+1 bits.
  - If trial ≥ 0, keep trial and set the quotient LSB to 1. Otherwise restore and set the LSB to 0.
  - After the N-th iteration, go to FIX.
- **FIX:** register the outputs, pulse done, drop busy, and return to IDLE.
  - quotient = sign_q ? −q_mag : q_mag; remainder = sign_r ? −r_mag : r_mag. Use N-bit two's complement with wrap.
  - Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1, overflow = 0.
  - Overflow (dividend = −2^(N−1), divisor = −1): q_mag = 2^(N−1) wraps to quotient = −2^(N−1), remainder = 0, overflow = 1.
  - Otherwise div_by_zero = 0 and overflow = 0.
- quotient, remainder, div_by_zero and overflow hold their values until the next FIX.
- start while busy is ignored. Operands may change freely after the accepting edge.
- Invariant for non-zero, non-overflow cases: dividend = quotient·divisor + remainder, |remainder| < |divisor|, and remainder is 0 or has the dividend's sign.

## Timing
- Reset: state IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0. Internal registers are cleared.
- Let edge k be the one that accepts start.
  - busy is 1 from after edge k up to edge k+N+1.
  - done is 1 for exactly the cycle after edge k+N+1, so latency is N+1 cycles.
  - For divisor = 0, done is high in the cycle after edge k+1, so latency is 1 cycle.
- busy and done are never high at the same time.
- Back-to-back operation: a start high during the done cycle is accepted (state is IDLE). Throughput is one result per N+1 cycles.
- rst asserted in any state aborts the operation at that edge. No done pulse is produced for it, and outputs return to 0.

## Test plan
- N=16, dividend=100, divisor=7, start for 1 cycle -> busy for 17 cycles, done one cycle later, quotient=14, remainder=2, flags 0.
- Sign matrix: −100/7 -> −14, −2; 100/−7 -> −14, 2; −100/−7 -> 14, −2; 3/10 -> 0, 3.
- Boundaries:
  - −32768/−1 -> quotient=−32768 (0x8000), remainder=0, overflow=1.
  - −32768/1 -> −32768, 0, overflow=0.
  - 32767/−32768 -> 0, 32767.
- 5/0 -> done in the cycle after the following edge; div_by_zero=1, quotient=0xFFFF, remainder=5.
- Start pulses during busy are ignored and outputs are unchanged. Start during the done cycle is accepted and its result is correct 17 cycles later.
- rst asserted at iteration 8 -> no done, all outputs 0. A new 1000/−33 afterwards -> −30, 10.
